// File: rtl/pattern_store.sv
// Double-buffered pattern store: a serial shadow bank is loaded over a scan chain.
// An exact-length frame is committed atomically into the active bank, which the processor reads and patches.
module pattern_store #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 27,
  parameter int unsigned PTR_W = 5
) (
  input  logic             sclk,
  input  logic             rst,
  input  logic             ssel,
  input  logic             sin,
  output logic             sout,
  input  logic [PTR_W-1:0] fieldp,
  output logic [WIDTH-1:0] field_byte,
  input  logic             wr_en,
  input  logic [PTR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             err_clr,
  output logic             commit,
  output logic             frame_err,
  output logic             busy
);

  localparam int unsigned TOTAL = WIDTH * DEPTH;
  localparam int unsigned CNT_W = $clog2(TOTAL + 2);
  localparam logic [CNT_W-1:0] TOTAL_C = CNT_W'(TOTAL);
  localparam logic [CNT_W-1:0] SAT_C   = CNT_W'(TOTAL + 1);

  logic [WIDTH-1:0] shadow_q [DEPTH];
  logic [WIDTH-1:0] shadow_d [DEPTH];
  logic [WIDTH-1:0] active_q [DEPTH];
  logic [WIDTH-1:0] active_d [DEPTH];
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ssel_q, ssel_d;
  logic             commit_q, commit_d;
  logic             err_q, err_d;
  logic             eof;
  logic             good;

  always_comb begin
    shadow_d = shadow_q;
    if (ssel) begin
      shadow_d[0] = {shadow_q[0][WIDTH-2:0], sin};
      for (int unsigned i = 1; i < DEPTH; i++) begin
        shadow_d[i] = {shadow_q[i][WIDTH-2:0], shadow_q[i-1][WIDTH-1]};
      end
    end
  end

  always_comb begin
    cnt_d = '0;
    if (ssel) begin
      cnt_d = (cnt_q == SAT_C) ? cnt_q : cnt_q + 1'b1;
    end
  end

  assign eof  = !ssel && ssel_q;
  assign good = eof && (cnt_q == TOTAL_C);

  // A commit takes the whole shadow bank, so any same-edge parallel write is dropped.
  always_comb begin
    active_d = active_q;
    if (good) begin
      active_d = shadow_q;
    end else if (wr_en) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (wr_addr == i[PTR_W-1:0]) begin
          active_d[i] = wr_data;
        end
      end
    end
  end

  always_comb begin
    ssel_d   = ssel;
    commit_d = good;
    err_d    = err_q;
    if (eof && !good) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end
  end

  always_comb begin
    field_byte = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (fieldp == i[PTR_W-1:0]) begin
        field_byte = active_q[i];
      end
    end
  end

  always_ff @(posedge sclk) begin
    if (rst) begin
      shadow_q <= '{default: '0};
      active_q <= '{default: '0};
      cnt_q    <= '0;
      ssel_q   <= 1'b0;
      commit_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
      cnt_q    <= cnt_d;
      ssel_q   <= ssel_d;
      commit_q <= commit_d;
      err_q    <= err_d;
    end
  end

  assign sout      = shadow_q[DEPTH-1][WIDTH-1];
  assign commit    = commit_q;
  assign frame_err = err_q;
  assign busy      = ssel_q;

endmodule

// File: tb/tb_pattern_store.sv
// Directed bench for pattern_store (WIDTH=8, DEPTH=4): table-driven writes/reads plus frame sequences.
// A second instance is daisy-chained off the first's sout.
module tb_pattern_store;

  logic       sclk = 1'b0;
  logic       rst = 1'b0;
  logic       ssel = 1'b0;
  logic       sin = 1'b0;
  logic [2:0] fieldp = '0;
  logic       wr_en = 1'b0;
  logic [2:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic       err_clr = 1'b0;

  logic       sout0, sout1;
  logic [7:0] fb0, fb1;
  logic       commit0, commit1, err0, err1, busy0, busy1;
  logic       wr_en1 = 1'b0;

  int tests = 0;
  int failed = 0;

  pattern_store #(.WIDTH(8), .DEPTH(4), .PTR_W(3)) u0 (
    .sclk(sclk), .rst(rst), .ssel(ssel), .sin(sin), .sout(sout0),
    .fieldp(fieldp), .field_byte(fb0), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .err_clr(err_clr), .commit(commit0),
    .frame_err(err0), .busy(busy0)
  );

  pattern_store #(.WIDTH(8), .DEPTH(4), .PTR_W(3)) u1 (
    .sclk(sclk), .rst(rst), .ssel(ssel), .sin(sout0), .sout(sout1),
    .fieldp(fieldp), .field_byte(fb1), .wr_en(wr_en1), .wr_addr(wr_addr),
    .wr_data(wr_data), .err_clr(err_clr), .commit(commit1),
    .frame_err(err1), .busy(busy1)
  );

  always #5 sclk = ~sclk;

  typedef struct {
    logic       we;
    logic [2:0] addr;
    logic [7:0] data;
    logic [2:0] fp;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge sclk);
    #1;
  endtask

  task automatic read0(input string name, input logic [2:0] fp, input logic [7:0] exp);
    fieldp = fp;
    #1;
    check(name, {24'b0, fb0}, {24'b0, exp});
  endtask

  task automatic shift_bits(input logic [63:0] data, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      ssel = 1'b1;
      sin  = data[i];
      tick();
    end
  endtask

  task automatic end_frame();
    ssel = 1'b0;
    sin  = 1'b0;
    tick();
  endtask

  task automatic clear_err();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
  endtask

  initial begin
    vecs[0] = '{we: 1'b1, addr: 3'd1, data: 8'h5A, fp: 3'd1, exp: 8'h5A};
    vecs[1] = '{we: 1'b1, addr: 3'd4, data: 8'h77, fp: 3'd0, exp: 8'h04};
    vecs[2] = '{we: 1'b0, addr: 3'd0, data: 8'h00, fp: 3'd7, exp: 8'h00};
    vecs[3] = '{we: 1'b1, addr: 3'd3, data: 8'hC6, fp: 3'd3, exp: 8'hC6};
    vecs[4] = '{we: 1'b1, addr: 3'd2, data: 8'h00, fp: 3'd1, exp: 8'h5A};
    vecs[5] = '{we: 1'b1, addr: 3'd2, data: 8'h00, fp: 3'd2, exp: 8'h00};

    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_commit", {31'b0, commit0}, 32'd0);
    check("rst_err", {31'b0, err0}, 32'd0);
    check("rst_busy", {31'b0, busy0}, 32'd0);
    check("rst_sout", {31'b0, sout0}, 32'd0);
    for (int i = 0; i < 4; i++) read0("rst_active", 3'(i), 8'h00);

    // Exact frame
    shift_bits(64'hA1B2C3D4, 32);
    check("busy_shift", {31'b0, busy0}, 32'd1);
    end_frame();
    check("commit_pulse", {31'b0, commit0}, 32'd1);
    check("commit_err", {31'b0, err0}, 32'd0);
    tick();
    check("commit_one_cycle", {31'b0, commit0}, 32'd0);
    read0("load_a3", 3'd3, 8'hA1);
    read0("load_a2", 3'd2, 8'hB2);
    read0("load_a1", 3'd1, 8'hC3);
    read0("load_a0", 3'd0, 8'hD4);

    // Short frame
    shift_bits(64'h7FFFFFFF, 31);
    end_frame();
    check("short_commit", {31'b0, commit0}, 32'd0);
    check("short_err", {31'b0, err0}, 32'd1);
    read0("short_keep", 3'd2, 8'hB2);
    clear_err();
    check("err_clr", {31'b0, err0}, 32'd0);

    // Long frame saturates the counter
    shift_bits(64'hFF_FFFFFFFF, 40);
    end_frame();
    check("long_commit", {31'b0, commit0}, 32'd0);
    check("long_err", {31'b0, err0}, 32'd1);
    read0("long_keep", 3'd0, 8'hD4);
    clear_err();
    shift_bits(64'h01020304, 32);
    end_frame();
    check("reload_commit", {31'b0, commit0}, 32'd1);
    read0("reload_a3", 3'd3, 8'h01);
    read0("reload_a0", 3'd0, 8'h04);
    check("reload_err", {31'b0, err0}, 32'd0);

    // Parallel write / read table
    for (int i = 0; i < 6; i++) begin
      wr_en   = vecs[i].we;
      wr_addr = vecs[i].addr;
      wr_data = vecs[i].data;
      tick();
      wr_en = 1'b0;
      read0($sformatf("vec%0d", i), vecs[i].fp, vecs[i].exp);
    end

    // Write on the commit edge loses to the commit
    shift_bits(64'h11223344, 32);
    ssel    = 1'b0;
    wr_en   = 1'b1;
    wr_addr = 3'd0;
    wr_data = 8'hFF;
    tick();
    wr_en = 1'b0;
    check("conflict_commit", {31'b0, commit0}, 32'd1);
    read0("conflict_a0", 3'd0, 8'h44);
    read0("conflict_a3", 3'd3, 8'h11);

    // Reset mid-frame with ssel held high
    shift_bits(64'h3FF, 10);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_busy", {31'b0, busy0}, 32'd0);
    check("midrst_sout", {31'b0, sout0}, 32'd0);
    check("midrst_err", {31'b0, err0}, 32'd0);
    for (int i = 0; i < 4; i++) read0("midrst_active", 3'(i), 8'h00);
    shift_bits(64'hCAFE1234, 32);
    end_frame();
    check("midrst_commit", {31'b0, commit0}, 32'd1);
    check("midrst_err2", {31'b0, err0}, 32'd0);
    read0("midrst_a3", 3'd3, 8'hCA);
    read0("midrst_a0", 3'd0, 8'h34);

    // Daisy chain: 64 bits is a long frame for each stage, but the data still splits across them
    clear_err();
    shift_bits(64'hDEADBEEF_0BADF00D, 64);
    end_frame();
    check("chain_commit0", {31'b0, commit0}, 32'd0);
    check("chain_commit1", {31'b0, commit1}, 32'd0);
    check("chain_err0", {31'b0, err0}, 32'd1);
    check("chain_err1", {31'b0, err1}, 32'd1);
    clear_err();
    begin
      logic [31:0] first_half;
      logic [31:0] new_word;
      first_half = 32'hDEADBEEF;
      new_word   = 32'h13579BDF;
      for (int k = 0; k < 32; k++) begin
        check("chain_sout1", {31'b0, sout1}, {31'b0, first_half[31-k]});
        ssel = 1'b1;
        sin  = new_word[31-k];
        tick();
      end
    end
    end_frame();
    check("chain2_commit0", {31'b0, commit0}, 32'd1);
    check("chain2_commit1", {31'b0, commit1}, 32'd1);
    fieldp = 3'd3;
    #1;
    check("chain_u1_a3", {24'b0, fb1}, 32'h0B);
    check("chain_u0_a3", {24'b0, fb0}, 32'h13);
    fieldp = 3'd0;
    #1;
    check("chain_u1_a0", {24'b0, fb1}, 32'h0D);
    check("chain_u0_a0", {24'b0, fb0}, 32'hDF);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
